// File: rtl/imlt_pipe_unit_pkg.sv
// Shared TPU execute-stage types: data width, command token and multiplier mode.
// Holds the typedefs and constants used by the pipelined multiplier and its bus.
package pkg_tpu;

    localparam int WIDTH_DATA     = 32;
    localparam int MLT_STAGES_DEF = 3;

    typedef logic [WIDTH_DATA-1:0] data_t;

    // Bit order matches OpCode[1:0]: hi in bit 1, sgn in bit 0.
    typedef struct packed {
        logic hi;
        logic sgn;
    } mlt_mode_t;

    typedef struct packed {
        logic [3:0] OpCode;
    } exe_op_t;

    typedef struct packed {
        exe_op_t    op;
        logic [4:0] rd;
        logic [6:0] tag;
    } pipe_exe_tmp_t;

    function automatic mlt_mode_t mlt_mode(input logic [1:0] opc);
        return mlt_mode_t'(opc);
    endfunction

endpackage

// File: rtl/imlt_pipe_unit_if.sv
// Issue/result bus of the pipelined multiplier; the issuer is master, the unit is slave.
interface imlt_pipe_unit_if import pkg_tpu::*; #(
    parameter int  WIDTH_D = WIDTH_DATA,
    parameter type TYPE    = pipe_exe_tmp_t
);
    logic               I_En;
    logic               I_Stall;
    logic [WIDTH_D-1:0] I_Data1;
    logic [WIDTH_D-1:0] I_Data2;
    TYPE                I_Token;
    logic               O_Valid;
    logic [WIDTH_D-1:0] O_Data;
    TYPE                O_Token;
    logic               O_Busy;

    modport master (
        output I_En, I_Stall, I_Data1, I_Data2, I_Token,
        input  O_Valid, O_Data, O_Token, O_Busy
    );

    modport slave (
        input  I_En, I_Stall, I_Data1, I_Data2, I_Token,
        output O_Valid, O_Data, O_Token, O_Busy
    );
endinterface

// File: rtl/imlt_pipe_unit_reg.sv
// One pipeline stage: valid, payload and token, frozen while en=0.
// Empty slots are loaded as all-zero so bubbles never leak stale data.
module imlt_pipe_reg #(
    parameter int  DW   = 8,
    parameter type TYPE = logic
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          vld_in,
    input  logic [DW-1:0] data_in,
    input  TYPE           tok_in,
    output logic          vld,
    output logic [DW-1:0] data,
    output TYPE           tok
);
    always_ff @(posedge clock) begin
        if (reset) begin
            vld  <= 1'b0;
            data <= '0;
            tok  <= '0;
        end else if (en) begin
            vld  <= vld_in;
            data <= vld_in ? data_in : '0;
            tok  <= vld_in ? tok_in : '0;
        end
    end
endmodule

// File: rtl/imlt_pipe_unit.sv
// Pipelined signed/unsigned WIDTH_D x WIDTH_D multiplier with half select and stall.
// Sign-magnitude datapath: abs in stage 0, unsigned multiply in stage 1, negate+select last.
module imlt_pipe_unit import pkg_tpu::*; #(
    parameter type TYPE       = pipe_exe_tmp_t,
    parameter int  NUM_STAGES = MLT_STAGES_DEF,
    parameter int  WIDTH_D    = WIDTH_DATA
) (
    input logic             clock,
    input logic             reset,
    imlt_pipe_unit_if.slave bus
);
    localparam int W  = WIDTH_D;
    localparam int PW = 2*W + 2;  // {neg, hi, 2W payload}

    // Payload after conditioning: {neg, hi, |a|, |b|}. -2^(W-1) maps to 2^(W-1) unsigned.
    function automatic logic [PW-1:0] cond_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input mlt_mode_t m);
        logic         sa, sb;
        logic [W-1:0] ma, mb;
        sa = m.sgn & a[W-1];
        sb = m.sgn & b[W-1];
        ma = sa ? -a : a;
        mb = sb ? -b : b;
        return {sa ^ sb, m.hi, ma, mb};
    endfunction

    function automatic logic [PW-1:0] mul_mag(input logic [PW-1:0] c);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, c[2*W-1:W]} * {{W{1'b0}}, c[W-1:0]};
        return {c[PW-1:PW-2], p};
    endfunction

    function automatic logic [W-1:0] fin_res(input logic [PW-1:0] c);
        logic [2*W-1:0] p;
        p = c[PW-1] ? -c[2*W-1:0] : c[2*W-1:0];
        return c[PW-2] ? p[2*W-1:W] : p[W-1:0];
    endfunction

    logic [NUM_STAGES-1:0] vld_pipe;
    logic                  en;

    assign en = ~bus.I_Stall;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stg
        localparam int DWI = (i == NUM_STAGES-1) ? W : PW;
        logic [DWI-1:0] din, q;
        logic           vin;
        TYPE            tin, tq;

        if (i == 0) begin : g_in
            assign vin = bus.I_En;
            assign tin = bus.I_Token;
            if (NUM_STAGES == 1) begin : g_one
                assign din = fin_res(mul_mag(cond_ops(bus.I_Data1, bus.I_Data2,
                                                      mlt_mode(bus.I_Token.op.OpCode[1:0]))));
            end else begin : g_cond
                assign din = cond_ops(bus.I_Data1, bus.I_Data2,
                                      mlt_mode(bus.I_Token.op.OpCode[1:0]));
            end
        end else begin : g_mid
            assign vin = vld_pipe[i-1];
            assign tin = g_stg[i-1].tq;
            if (i == 1 && i == NUM_STAGES-1) begin : g_mul_fin
                assign din = fin_res(mul_mag(g_stg[i-1].q));
            end else if (i == NUM_STAGES-1) begin : g_fin
                assign din = fin_res(g_stg[i-1].q);
            end else if (i == 1) begin : g_mul
                assign din = mul_mag(g_stg[i-1].q);
            end else begin : g_pass
                assign din = g_stg[i-1].q;
            end
        end

        imlt_pipe_reg #(.DW(DWI), .TYPE(TYPE)) u_reg (
            .clock   (clock),
            .reset   (reset),
            .en      (en),
            .vld_in  (vin),
            .data_in (din),
            .tok_in  (tin),
            .vld     (vld_pipe[i]),
            .data    (q),
            .tok     (tq)
        );
    end

    assign bus.O_Valid = vld_pipe[NUM_STAGES-1];
    assign bus.O_Data  = g_stg[NUM_STAGES-1].q;
    assign bus.O_Token = g_stg[NUM_STAGES-1].tq;
    assign bus.O_Busy  = |vld_pipe;

endmodule
